// File: rtl/sdram_pkg.sv
// Shared SDRAM constants: bus widths, command encodings and arbiter state encoding.
package sdram_pkg;

  localparam int CMD_W  = 4;
  localparam int ADDR_W = 13;
  localparam int BA_W   = 2;
  localparam int DQ_W   = 16;

  // {cs_n, ras_n, cas_n, we_n}
  localparam logic [CMD_W-1:0] CMD_NOP  = 4'b0111;
  localparam logic [CMD_W-1:0] CMD_PRE  = 4'b0010;
  localparam logic [CMD_W-1:0] CMD_AREF = 4'b0001;
  localparam logic [CMD_W-1:0] CMD_MRS  = 4'b0000;
  localparam logic [CMD_W-1:0] CMD_ACT  = 4'b0011;
  localparam logic [CMD_W-1:0] CMD_WR   = 4'b0100;
  localparam logic [CMD_W-1:0] CMD_RD   = 4'b0101;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_ARBIT,
    ST_AREF,
    ST_WRITE,
    ST_READ
  } state_e;

endpackage

// File: rtl/sdram_arbit.sv
// SDRAM bus arbiter: grants refresh, write or read ownership of the pins and
// drives the registered command/address/data pads from the owner.
module sdram_arbit
  import sdram_pkg::CMD_W;
  import sdram_pkg::ADDR_W;
  import sdram_pkg::BA_W;
  import sdram_pkg::DQ_W;
  import sdram_pkg::state_e;
  import sdram_pkg::ST_INIT;
  import sdram_pkg::ST_ARBIT;
  import sdram_pkg::ST_AREF;
  import sdram_pkg::ST_WRITE;
  import sdram_pkg::ST_READ;
#(
  parameter int               WR_STREAK_MAX = 4,
  parameter int               TIMEOUT       = 1023,
  parameter logic [CMD_W-1:0] CMD_NOP       = sdram_pkg::CMD_NOP
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              init_end,
  input  logic [CMD_W-1:0]  init_cmd,
  input  logic [BA_W-1:0]   init_ba,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic              aref_req,
  input  logic              aref_end,
  input  logic [CMD_W-1:0]  aref_cmd,
  input  logic [BA_W-1:0]   aref_ba,
  input  logic [ADDR_W-1:0] aref_addr,
  input  logic              wr_req,
  input  logic              wr_end,
  input  logic [CMD_W-1:0]  wr_cmd,
  input  logic [BA_W-1:0]   wr_ba,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              wr_sdram_en,
  input  logic [DQ_W-1:0]   wr_sdram_data,
  input  logic              rd_req,
  input  logic              rd_end,
  input  logic [CMD_W-1:0]  rd_cmd,
  input  logic [BA_W-1:0]   rd_ba,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              aref_en,
  output logic              wr_en,
  output logic              rd_en,
  output logic              sdram_cke,
  output logic              sdram_cs_n,
  output logic              sdram_ras_n,
  output logic              sdram_cas_n,
  output logic              sdram_we_n,
  output logic [BA_W-1:0]   sdram_ba,
  output logic [ADDR_W-1:0] sdram_addr,
  output logic [DQ_W-1:0]   sdram_dq_out,
  output logic              sdram_dq_oe,
  output logic              err_timeout
);

  localparam int STREAK_W = $clog2(WR_STREAK_MAX + 1);
  localparam int WD_W     = $clog2(TIMEOUT + 1);
  localparam logic [STREAK_W-1:0] STREAK_TOP = STREAK_W'(WR_STREAK_MAX);
  localparam logic [WD_W-1:0]     WD_LAST    = WD_W'(TIMEOUT - 1);

  state_e              state, state_nxt;
  logic [STREAK_W-1:0] streak;
  logic [WD_W-1:0]     wd;
  logic                in_op;
  logic                op_done;
  logic                wd_expire;

  logic [CMD_W-1:0]    cmd_nxt;
  logic [BA_W-1:0]     ba_nxt;
  logic [ADDR_W-1:0]   addr_nxt;
  logic [DQ_W-1:0]     dq_nxt;
  logic                oe_nxt;

  assign in_op = (state == ST_AREF) || (state == ST_WRITE) || (state == ST_READ);

  // NOTE: every signal written in an always_comb gets a default first, so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    op_done   = 1'b0;
    wd_expire = 1'b0;
    case (state)
      ST_INIT: if (init_end) state_nxt = ST_ARBIT;
      ST_ARBIT: begin
        if (aref_req)                                     state_nxt = ST_AREF;
        else if (wr_req && !(rd_req && streak == STREAK_TOP)) state_nxt = ST_WRITE;
        else if (rd_req)                                  state_nxt = ST_READ;
      end
      ST_AREF:  op_done = aref_end;
      ST_WRITE: op_done = wr_end;
      ST_READ:  op_done = rd_end;
      default:  state_nxt = ST_INIT;
    endcase
    // An end pulse on the expiry cycle is a normal completion, not an error.
    if (in_op) begin
      wd_expire = !op_done && (wd == WD_LAST);
      if (op_done || wd_expire) state_nxt = ST_ARBIT;
    end
  end

  // Pads are registered from the upcoming owner so they switch with the grant.
  always_comb begin
    cmd_nxt  = CMD_NOP;
    ba_nxt   = '0;
    addr_nxt = '0;
    dq_nxt   = '0;
    oe_nxt   = 1'b0;
    case (state_nxt)
      ST_INIT: begin
        cmd_nxt  = init_cmd;
        ba_nxt   = init_ba;
        addr_nxt = init_addr;
      end
      ST_AREF: begin
        cmd_nxt  = aref_cmd;
        ba_nxt   = aref_ba;
        addr_nxt = aref_addr;
      end
      ST_WRITE: begin
        cmd_nxt  = wr_cmd;
        ba_nxt   = wr_ba;
        addr_nxt = wr_addr;
        dq_nxt   = wr_sdram_data;
        oe_nxt   = wr_sdram_en;
      end
      ST_READ: begin
        cmd_nxt  = rd_cmd;
        ba_nxt   = rd_ba;
        addr_nxt = rd_addr;
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state        <= ST_INIT;
      streak       <= '0;
      wd           <= '0;
      err_timeout  <= 1'b0;
      {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} <= CMD_NOP;
      sdram_ba     <= '0;
      sdram_addr   <= '0;
      sdram_dq_out <= '0;
      sdram_dq_oe  <= 1'b0;
    end else begin
      state        <= state_nxt;
      err_timeout  <= wd_expire;
      {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} <= cmd_nxt;
      sdram_ba     <= ba_nxt;
      sdram_addr   <= addr_nxt;
      sdram_dq_out <= dq_nxt;
      sdram_dq_oe  <= oe_nxt;
      wd           <= in_op ? wd + 1'b1 : '0;
      // Fairness: count writes granted while a read waits; a read or an idle
      // read request resets the streak.
      if (state == ST_ARBIT) begin
        if (!rd_req || state_nxt == ST_READ)
          streak <= '0;
        else if (state_nxt == ST_WRITE && streak != STREAK_TOP)
          streak <= streak + 1'b1;
      end
    end
  end

  assign aref_en   = (state == ST_AREF);
  assign wr_en     = (state == ST_WRITE);
  assign rd_en     = (state == ST_READ);
  assign sdram_cke = 1'b1;

endmodule

// File: tb/tb_sdram_arbit.sv
// Self-checking bench for sdram_arbit: directed vector table, hand-written
// corner sequences and a randomized run against a behavioural model.
module tb_sdram_arbit;
  import sdram_pkg::*;

  localparam int TB_TIMEOUT = 16;
  localparam int TB_STREAK  = 4;
  localparam logic [3:0] C_INIT = 4'b0010;
  localparam logic [3:0] C_AREF = 4'b0001;
  localparam logic [3:0] C_WR   = 4'b0100;
  localparam logic [3:0] C_RD   = 4'b0101;
  localparam logic [3:0] C_NOP  = 4'b0111;

  logic sys_clk = 1'b0;
  logic sys_rst;
  logic init_end, aref_req, aref_end, wr_req, wr_end, rd_req, rd_end, wr_sdram_en;
  logic [3:0]  init_cmd, aref_cmd, wr_cmd, rd_cmd;
  logic [1:0]  init_ba, aref_ba, wr_ba, rd_ba;
  logic [12:0] init_addr, aref_addr, wr_addr, rd_addr;
  logic [15:0] wr_sdram_data;
  logic aref_en, wr_en, rd_en, sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n;
  logic [1:0]  sdram_ba;
  logic [12:0] sdram_addr;
  logic [15:0] sdram_dq_out;
  logic sdram_dq_oe, err_timeout;

  int n_vec = 0;
  int n_bad = 0;

  sdram_arbit #(.WR_STREAK_MAX(TB_STREAK), .TIMEOUT(TB_TIMEOUT)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .init_end(init_end),
    .init_cmd(init_cmd), .init_ba(init_ba), .init_addr(init_addr),
    .aref_req(aref_req), .aref_end(aref_end), .aref_cmd(aref_cmd),
    .aref_ba(aref_ba), .aref_addr(aref_addr),
    .wr_req(wr_req), .wr_end(wr_end), .wr_cmd(wr_cmd), .wr_ba(wr_ba),
    .wr_addr(wr_addr), .wr_sdram_en(wr_sdram_en), .wr_sdram_data(wr_sdram_data),
    .rd_req(rd_req), .rd_end(rd_end), .rd_cmd(rd_cmd), .rd_ba(rd_ba), .rd_addr(rd_addr),
    .aref_en(aref_en), .wr_en(wr_en), .rd_en(rd_en), .sdram_cke(sdram_cke),
    .sdram_cs_n(sdram_cs_n), .sdram_ras_n(sdram_ras_n), .sdram_cas_n(sdram_cas_n),
    .sdram_we_n(sdram_we_n), .sdram_ba(sdram_ba), .sdram_addr(sdram_addr),
    .sdram_dq_out(sdram_dq_out), .sdram_dq_oe(sdram_dq_oe), .err_timeout(err_timeout)
  );

  always #5 sys_clk = ~sys_clk;

  initial begin
    #500000;
    $display("FAIL global_time_limit: simulation did not finish");
    $fatal(1, "time limit");
  end

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [2:0] gnt();
    return {aref_en, wr_en, rd_en};
  endfunction

  function automatic logic [3:0] pins();
    return {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n};
  endfunction

  // Directed vectors: inputs held during one cycle, outputs expected after the edge.
  typedef struct {
    bit rst, ie, ar, wr, rd, ae, we, re;
    bit [2:0] gnt;
    bit [3:0] cmd;
    bit err;
  } vec_t;
  vec_t tbl[$];

  // Behavioural model: who owns the bus, how long it has held it, and how
  // many writes have jumped a waiting read.
  bit m_init;
  int m_owner;   // 0 none, 1 refresh, 2 write, 3 read
  int m_run;
  int m_wrrun;
  logic [40:0] m_exp;

  task automatic model_step();
    bit done, e_err;
    logic [3:0] e_cmd;
    logic [1:0] e_ba;
    logic [12:0] e_addr;
    logic [15:0] e_dq;
    logic e_oe;
    e_err = 1'b0;
    if (sys_rst) begin
      m_init = 1'b1; m_owner = 0; m_run = 0; m_wrrun = 0;
    end else if (m_init) begin
      if (init_end) m_init = 1'b0;
    end else if (m_owner == 0) begin
      if (!rd_req) m_wrrun = 0;
      if (aref_req) m_owner = 1;
      else if (wr_req && !(rd_req && m_wrrun == TB_STREAK)) begin
        m_owner = 2;
        if (rd_req && m_wrrun < TB_STREAK) m_wrrun = m_wrrun + 1;
      end else if (rd_req) begin
        m_owner = 3; m_wrrun = 0;
      end
      m_run = 0;
    end else begin
      done = (m_owner == 1 && aref_end) || (m_owner == 2 && wr_end) || (m_owner == 3 && rd_end);
      if (done) m_owner = 0;
      else begin
        m_run = m_run + 1;
        if (m_run == TB_TIMEOUT) begin m_owner = 0; e_err = 1'b1; end
      end
    end
    e_cmd = C_NOP; e_ba = '0; e_addr = '0; e_dq = '0; e_oe = 1'b0;
    if (!sys_rst) begin
      if (m_init) begin e_cmd = init_cmd; e_ba = init_ba; e_addr = init_addr; end
      else if (m_owner == 1) begin e_cmd = aref_cmd; e_ba = aref_ba; e_addr = aref_addr; end
      else if (m_owner == 2) begin
        e_cmd = wr_cmd; e_ba = wr_ba; e_addr = wr_addr; e_dq = wr_sdram_data; e_oe = wr_sdram_en;
      end else if (m_owner == 3) begin e_cmd = rd_cmd; e_ba = rd_ba; e_addr = rd_addr; end
    end
    m_exp = {(!sys_rst && !m_init && m_owner == 1), (!sys_rst && !m_init && m_owner == 2),
             (!sys_rst && !m_init && m_owner == 3), e_cmd, e_ba, e_addr, e_oe, e_dq, e_err, 1'b1};
  endtask

  initial begin
    int waited;
    logic [2:0] exp_g;

    sys_rst = 1'b1; init_end = 0; aref_req = 0; aref_end = 0; wr_req = 0; wr_end = 0;
    rd_req = 0; rd_end = 0; wr_sdram_en = 0; wr_sdram_data = '0;
    init_cmd = C_INIT; aref_cmd = C_AREF; wr_cmd = C_WR; rd_cmd = C_RD;
    init_ba = 2'd1; aref_ba = 2'd0; wr_ba = 2'd2; rd_ba = 2'd3;
    init_addr = 13'h0400; aref_addr = 13'h0; wr_addr = 13'h0123; rd_addr = 13'h1abc;

    //          rst ie ar wr rd ae we re  gnt     cmd    err
    tbl.push_back('{1, 0, 0, 0, 0, 0, 0, 0, 3'b000, C_NOP,  0});
    tbl.push_back('{1, 0, 0, 0, 0, 0, 0, 0, 3'b000, C_NOP,  0});
    tbl.push_back('{1, 0, 0, 0, 0, 0, 0, 0, 3'b000, C_NOP,  0});
    tbl.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 3'b000, C_INIT, 0});
    tbl.push_back('{0, 0, 1, 1, 1, 0, 0, 0, 3'b000, C_INIT, 0});
    tbl.push_back('{0, 1, 1, 1, 1, 0, 0, 0, 3'b000, C_NOP,  0});
    tbl.push_back('{0, 0, 1, 1, 1, 0, 0, 0, 3'b100, C_AREF, 0});
    tbl.push_back('{0, 0, 1, 1, 1, 0, 1, 1, 3'b100, C_AREF, 0});
    tbl.push_back('{0, 0, 0, 1, 1, 1, 0, 0, 3'b000, C_NOP,  0});
    tbl.push_back('{0, 1, 0, 1, 1, 0, 0, 0, 3'b010, C_WR,   0});
    tbl.push_back('{0, 0, 0, 1, 1, 1, 0, 1, 3'b010, C_WR,   0});
    tbl.push_back('{0, 0, 0, 1, 1, 0, 1, 0, 3'b000, C_NOP,  0});
    tbl.push_back('{0, 0, 0, 1, 1, 0, 0, 0, 3'b010, C_WR,   0});
    tbl.push_back('{0, 0, 0, 1, 1, 0, 1, 0, 3'b000, C_NOP,  0});
    tbl.push_back('{0, 0, 0, 1, 1, 0, 0, 0, 3'b010, C_WR,   0});
    tbl.push_back('{0, 0, 0, 1, 1, 0, 1, 0, 3'b000, C_NOP,  0});
    tbl.push_back('{0, 0, 0, 1, 1, 0, 0, 0, 3'b010, C_WR,   0});
    tbl.push_back('{0, 0, 0, 1, 1, 0, 1, 0, 3'b000, C_NOP,  0});
    tbl.push_back('{0, 0, 0, 1, 1, 0, 0, 0, 3'b001, C_RD,   0});
    tbl.push_back('{0, 0, 0, 1, 1, 0, 0, 1, 3'b000, C_NOP,  0});
    tbl.push_back('{0, 0, 0, 1, 1, 0, 0, 0, 3'b010, C_WR,   0});
    tbl.push_back('{0, 0, 0, 1, 1, 0, 1, 0, 3'b000, C_NOP,  0});
    tbl.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 3'b000, C_NOP,  0});
    tbl.push_back('{0, 0, 1, 0, 0, 0, 0, 0, 3'b100, C_AREF, 0});
    tbl.push_back('{0, 0, 0, 0, 0, 1, 0, 0, 3'b000, C_NOP,  0});

    foreach (tbl[i]) begin
      sys_rst = tbl[i].rst; init_end = tbl[i].ie; aref_req = tbl[i].ar; wr_req = tbl[i].wr;
      rd_req = tbl[i].rd; aref_end = tbl[i].ae; wr_end = tbl[i].we; rd_end = tbl[i].re;
      tick();
      check($sformatf("tbl%0d_grant", i), gnt(), tbl[i].gnt);
      check($sformatf("tbl%0d_cmd", i), pins(), tbl[i].cmd);
      check($sformatf("tbl%0d_err", i), err_timeout, tbl[i].err);
      if (i == 0) check("reset_cke", sdram_cke, 1'b1);
    end
    aref_end = 0; init_end = 0;

    // Write data path, then the same data inputs while reading.
    wr_req = 1; wr_sdram_en = 1; wr_sdram_data = 16'hA5A5;
    tick();
    check("wdata_oe", sdram_dq_oe, 1'b1);
    check("wdata_dq", sdram_dq_out, 16'hA5A5);
    tick();
    check("wdata_oe_hold", sdram_dq_oe, 1'b1);
    wr_req = 0; wr_end = 1;
    tick();
    wr_end = 0;
    check("wdata_oe_release", sdram_dq_oe, 1'b0);
    rd_req = 1;
    tick();
    check("rdata_grant", gnt(), 3'b001);
    check("rdata_oe", sdram_dq_oe, 1'b0);
    check("rdata_dq", sdram_dq_out, 16'h0000);
    rd_req = 0; rd_end = 1;
    tick();
    rd_end = 0;

    // Reset in the middle of a write drops the grant and the pads at once.
    wr_req = 1;
    tick();
    check("midrst_pre_oe", sdram_dq_oe, 1'b1);
    sys_rst = 1;
    tick();
    check("midrst_grant", gnt(), 3'b000);
    check("midrst_oe", sdram_dq_oe, 1'b0);
    check("midrst_cmd", pins(), C_NOP);
    sys_rst = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("midrst_init%0d_grant", k), gnt(), 3'b000);
      check($sformatf("midrst_init%0d_cmd", k), pins(), C_INIT);
    end
    init_end = 1;
    tick();
    init_end = 0;
    check("midrst_arbit_cmd", pins(), C_NOP);
    tick();
    check("midrst_regrant", gnt(), 3'b010);
    wr_req = 0; wr_end = 1; wr_sdram_en = 0;
    tick();
    wr_end = 0;
    tick();

    // Starvation guard: four writes then one forced read, repeatedly.
    wr_req = 1; rd_req = 1;
    for (int g = 0; g < 10; g++) begin
      waited = 0;
      while (gnt() == 3'b000 && waited < 4) begin tick(); waited++; end
      exp_g = (g % 5 == 4) ? 3'b001 : 3'b010;
      check($sformatf("starve_grant%0d", g), gnt(), exp_g);
      repeat (7) tick();
      if (wr_en) wr_end = 1;
      if (rd_en) rd_end = 1;
      tick();
      wr_end = 0; rd_end = 0;
      check($sformatf("starve_release%0d", g), gnt(), 3'b000);
    end
    wr_req = 0; rd_req = 0;
    tick();

    // Watchdog: read never ends, then ends exactly on the expiry cycle.
    rd_req = 1;
    tick();
    rd_req = 0;
    check("wd_entry", gnt(), 3'b001);
    for (int k = 1; k < TB_TIMEOUT; k++) begin
      tick();
      check($sformatf("wd_run%0d", k), {gnt(), err_timeout}, {3'b001, 1'b0});
    end
    tick();
    check("wd_expire", {gnt(), err_timeout}, {3'b000, 1'b1});
    tick();
    check("wd_pulse_end", err_timeout, 1'b0);
    rd_req = 1;
    tick();
    rd_req = 0;
    repeat (TB_TIMEOUT - 1) tick();
    check("wd_late_still_granted", gnt(), 3'b001);
    rd_end = 1;
    tick();
    rd_end = 0;
    check("wd_late_end", {gnt(), err_timeout}, {3'b000, 1'b0});
    tick();
    check("wd_late_no_err", err_timeout, 1'b0);

    // Randomized run against the model.
    for (int c = 0; c < 3000; c++) begin
      sys_rst  = (c == 0) || ($urandom_range(0, 199) == 0);
      init_end = ($urandom_range(0, 7) == 0);
      aref_req = ($urandom_range(0, 15) == 0);
      wr_req   = ($urandom_range(0, 2) != 0);
      rd_req   = 1'($urandom_range(0, 1));
      aref_end = ($urandom_range(0, 9) == 0);
      wr_end   = ($urandom_range(0, 9) == 0);
      rd_end   = ($urandom_range(0, 9) == 0);
      init_cmd = 4'($urandom); aref_cmd = 4'($urandom); wr_cmd = 4'($urandom); rd_cmd = 4'($urandom);
      init_ba = 2'($urandom); aref_ba = 2'($urandom); wr_ba = 2'($urandom); rd_ba = 2'($urandom);
      init_addr = 13'($urandom); aref_addr = 13'($urandom); wr_addr = 13'($urandom); rd_addr = 13'($urandom);
      wr_sdram_en = 1'($urandom); wr_sdram_data = 16'($urandom);
      model_step();
      tick();
      check($sformatf("rand_cycle%0d", c),
            {gnt(), pins(), sdram_ba, sdram_addr, sdram_dq_oe, sdram_dq_out, err_timeout, sdram_cke},
            m_exp);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
